prco_sequencer: RTL and testbench
=================================

Name: prco_sequencer

Overview:
- Parametrised instruction sequencer for the prco core. Owns the PC, issues fetch strobes into the pipeline, absorbs retire/branch/halt events from downstream stages, and supports run, single-step and hardware breakpoints.
- Replaces the ad-hoc core_state branch fix with an explicit FSM and a configurable branch flush length.
- Sits between the debug controls and the local-memory fetch port.

Parameters:
- PC_W, 16, PC and branch-target width.
- RESET_VEC, 0, PC value loaded on reset.
- FLUSH_CYCLES, 3, idle cycles after a taken branch before the next issue (≥1).
- NUM_BP, 2, number of breakpoint comparators (≥1).
- CNT_W, 32, retired-instruction counter width.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous reset, active-high
- i_mode  in  1  0 = free run, 1 = single-step
- i_step  in  1  step request; rising edge detected internally
- i_done  in  1  1-cycle pulse: current instruction retired, pipeline ready
- i_branch  in  1  1-cycle pulse: branch taken for current instruction
- i_branch_target  in  PC_W  branch destination, valid with i_branch
- i_halt  in  1  1-cycle pulse: halt instruction retired
- i_resume  in  1  leave HALT
- i_bp_wr  in  1  write breakpoint entry
- i_bp_idx  in  $clog2(NUM_BP) (min 1)  entry index
- i_bp_addr  in  PC_W  breakpoint address
- i_bp_en  in  1  entry enable written with i_bp_wr
- q_pc  out  PC_W  address of the instruction being issued or executed
- q_fetch_ce  out  1  1-cycle issue strobe to the fetch stage
- q_instr_clk  out  1  1-cycle pulse per retired instruction (debug LED)
- q_halted  out  1  high while in HALT
- q_bp_hit  out  1  high while halted by a breakpoint
- q_state  out  3  FSM state encoding, for debug
- q_retired  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- Reset values: all outputs 0, except q_pc = RESET_VEC. State INIT. Breakpoint enables cleared; step latch, skip flag and flush counter cleared. Reset mid-operation aborts any state immediately.
- States: INIT=0, ISSUE=1, WAIT=2, FLUSH=3, HALT=4.
- INIT: unconditionally → ISSUE on the next cycle (jump-start).
- ISSUE:
  - If an enabled breakpoint matches q_pc and skip=0: → HALT with q_bp_hit=1; no strobe.
  - Else, if i_mode=1 and no step is latched: remain in ISSUE.
  - Else: q_fetch_ce=1 for exactly one cycle, clear the step latch and skip flag, → WAIT.
- WAIT, per-cycle priority halt > branch > done:
  - i_halt: q_pc += 1, retired += 1, q_instr_clk pulse, → HALT (q_bp_hit=0).
  - i_branch: q_pc <= i_branch_target, retired += 1, pulse, load counter with FLUSH_CYCLES-1, → FLUSH. A simultaneous i_done is ignored.
  - i_done: q_pc += 1, retired += 1, pulse, → ISSUE.
  - Otherwise hold.
- FLUSH: decrement the counter; when the counter is 0, → ISSUE. The first post-branch strobe therefore occurs FLUSH_CYCLES+1 cycles after the i_branch pulse.
- HALT:
  - q_halted=1.
  - i_resume → ISSUE, clear q_bp_hit, set skip=1 so the breakpoint at the current PC does not re-trigger once.
  - i_resume while i_mode=1 still requires a step to issue.
- Step latch: set on a rising edge of i_step in any state. Only one step is queued; extra edges before consumption are dropped.
- i_done, i_branch and i_halt outside WAIT are ignored.
- PC increments wrap from 2^PC_W-1 to 0.
- Breakpoint write takes effect the cycle after i_bp_wr. A write to the entry matching q_pc in that same cycle has no effect on that cycle's comparison.
- Latency: ISSUE→strobe is the same cycle. done→next strobe is 1 cycle (WAIT→ISSUE, strobe in ISSUE).

Decomposition:
- Shared package prco_seq_pkg:
  - State encodings.
  - Mode constants RUN=0 and STEP=1.
  - Default FLUSH_CYCLES.
- Sub-module prco_bp_match: NUM_BP address/enable register file plus the parallel comparator, producing hit = OR(en_i & (addr_i == pc)).

Test Plan:
- Reset and free run: release reset with done pulsed 1 cycle after each strobe → strobes at PCs 0, 1, 2, 3; q_retired=4; q_instr_clk pulses 4 times.
- Branch: at PC 5, pulse i_branch with target 0x0040 → no strobe for 4 cycles (FLUSH_CYCLES=3), then strobe with q_pc=0x0040; retired increments by 1.
- Priority: pulse i_halt, i_branch and i_done together at PC 7 → state HALT, q_pc=8, q_halted=1, q_bp_hit=0; i_resume → strobe at PC 8.
- Breakpoint: program bp0=0x0003 enabled → HALT entered at PC 3 with q_bp_hit=1 and no strobe; i_resume → strobe at PC 3 with no re-trigger; the next pass through PC 3 halts again.
- Step mode: i_mode=1 with two i_step edges in consecutive cycles → exactly one strobe; a third edge after done → one more strobe.
- Wrap and async reset: PC_W=4, free run from 0xE → strobes at 0xE, 0xF, 0x0. Assert i_reset mid-WAIT → q_pc=RESET_VEC and q_fetch_ce=0 with no clock edge needed.

Source files
------------

// File: rtl/prco_seq_pkg.sv
// prco_seq_pkg: shared state/mode encodings and sizing helper for the prco sequencer
package prco_seq_pkg;
  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_FLUSH = 3'd3,
    S_HALT  = 3'd4
  } state_e;
  localparam logic MODE_RUN = 1'b0;
  localparam logic MODE_STEP = 1'b1;
  localparam int DEFAULT_FLUSH_CYCLES = 3;
  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/prco_bp_match.sv
// prco_bp_match: breakpoint address/enable register file with a parallel PC comparator
module prco_bp_match
  import prco_seq_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int NUM_BP = 2,
  localparam int IDX_W = cnt_w(NUM_BP)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             wr_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [PC_W-1:0]  addr_i,
  input  logic             en_i,
  input  logic [PC_W-1:0]  pc_i,
  output logic             hit_o
);
  logic [PC_W-1:0] addr_q [NUM_BP];
  logic [NUM_BP-1:0] en_q;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      addr_q <= '{default: '0};
      en_q <= '0;
    end else if (wr_i) begin
      addr_q[idx_i] <= addr_i;
      en_q[idx_i] <= en_i;
    end
  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < NUM_BP; i++) hit_o = hit_o | (en_q[i] && addr_q[i] == pc_i);
  end
endmodule

// File: rtl/prco_sequencer.sv
// prco_sequencer: owns the PC and the issue FSM; handles retire, branch flush,
// halt/resume, single-step and hardware breakpoints.
module prco_sequencer
  import prco_seq_pkg::*;
#(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
  parameter int NUM_BP = 2,
  parameter int CNT_W = 32,
  localparam int IDX_W = cnt_w(NUM_BP),
  localparam int FL_W = cnt_w(FLUSH_CYCLES)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_mode,
  input  logic             i_step,
  input  logic             i_done,
  input  logic             i_branch,
  input  logic [PC_W-1:0]  i_branch_target,
  input  logic             i_halt,
  input  logic             i_resume,
  input  logic             i_bp_wr,
  input  logic [IDX_W-1:0] i_bp_idx,
  input  logic [PC_W-1:0]  i_bp_addr,
  input  logic             i_bp_en,
  output logic [PC_W-1:0]  q_pc,
  output logic             q_fetch_ce,
  output logic             q_instr_clk,
  output logic             q_halted,
  output logic             q_bp_hit,
  output logic [2:0]       q_state,
  output logic [CNT_W-1:0] q_retired
);
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [FL_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic bp_hit_q, bp_hit_d, skip_q, skip_d, step_q, step_d, step_prev_q;
  logic hit, bp_stop, fetch, retire, taken, resume;
  prco_bp_match #(.PC_W(PC_W), .NUM_BP(NUM_BP)) u_bp (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .wr_i   (i_bp_wr),
    .idx_i  (i_bp_idx),
    .addr_i (i_bp_addr),
    .en_i   (i_bp_en),
    .pc_i   (pc_q),
    .hit_o  (hit)
  );
  // skip lets the instruction we were stopped on issue once after resume
  assign bp_stop = state_q == S_ISSUE && hit && !skip_q;
  assign fetch = state_q == S_ISSUE && !bp_stop && (i_mode != MODE_STEP || step_q);
  assign retire = state_q == S_WAIT && (i_halt || i_branch || i_done);
  assign taken = state_q == S_WAIT && !i_halt && i_branch;
  assign resume = state_q == S_HALT && i_resume;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state_q <= S_INIT;
      pc_q <= RESET_VEC;
      cnt_q <= '0;
      ret_q <= '0;
      bp_hit_q <= 1'b0;
      skip_q <= 1'b0;
      step_q <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      ret_q <= ret_d;
      bp_hit_q <= bp_hit_d;
      skip_q <= skip_d;
      step_q <= step_d;
      step_prev_q <= i_step;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = S_ISSUE;
      S_ISSUE: state_d = bp_stop ? S_HALT : fetch ? S_WAIT : S_ISSUE;
      S_WAIT:  state_d = i_halt ? S_HALT : i_branch ? S_FLUSH : i_done ? S_ISSUE : S_WAIT;
      S_FLUSH: state_d = cnt_q == '0 ? S_ISSUE : S_FLUSH;
      S_HALT:  state_d = i_resume ? S_ISSUE : S_HALT;
      default: state_d = S_INIT;
    endcase
    pc_d = taken ? i_branch_target : retire ? pc_q + PC_W'(1) : pc_q;
    cnt_d = taken ? FL_W'(FLUSH_CYCLES - 1) : (state_q == S_FLUSH && cnt_q != '0) ? cnt_q - FL_W'(1) : cnt_q;
    ret_d = ret_q + CNT_W'(retire);
    bp_hit_d = bp_stop ? 1'b1 : resume ? 1'b0 : bp_hit_q;
    skip_d = resume ? 1'b1 : fetch ? 1'b0 : skip_q;
    step_d = fetch ? 1'b0 : step_q | (i_step && !step_prev_q);
  end
  always_comb begin
    q_pc = pc_q;
    q_fetch_ce = fetch;
    q_instr_clk = retire;
    q_halted = state_q == S_HALT;
    q_bp_hit = bp_hit_q;
    q_state = state_q;
    q_retired = ret_q;
  end
endmodule

// File: tb/tb_prco_sequencer.sv
// tb_prco_sequencer: scoreboard bench; stimulus queues expected strobe PCs, monitors pop and compare.
module tb_prco_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, mode, step, done, branch, halt, resume, bp_wr, bp_idx, bp_en;
  logic [15:0] tgt, bp_addr, pc;
  logic fetch, iclk, halted, bp_hit;
  logic [2:0] state;
  logic [31:0] retired;
  logic w_rst, w_done, w_fetch, w_iclk, w_halted, w_bp_hit;
  logic [3:0] w_pc;
  logic [2:0] w_state;
  logic [31:0] w_retired;
  int checks = 0, errors = 0, pulses = 0, wseen = 0;
  logic [15:0] exp_q[$];
  logic [3:0] wq[$];

  prco_sequencer dut (
    .i_clk(clk), .i_reset(rst), .i_mode(mode), .i_step(step), .i_done(done),
    .i_branch(branch), .i_branch_target(tgt), .i_halt(halt), .i_resume(resume),
    .i_bp_wr(bp_wr), .i_bp_idx(bp_idx), .i_bp_addr(bp_addr), .i_bp_en(bp_en),
    .q_pc(pc), .q_fetch_ce(fetch), .q_instr_clk(iclk), .q_halted(halted),
    .q_bp_hit(bp_hit), .q_state(state), .q_retired(retired)
  );

  prco_sequencer #(.PC_W(4), .RESET_VEC(4'hE)) dut_w (
    .i_clk(clk), .i_reset(w_rst), .i_mode(1'b0), .i_step(1'b0), .i_done(w_done),
    .i_branch(1'b0), .i_branch_target(4'h0), .i_halt(1'b0), .i_resume(1'b0),
    .i_bp_wr(1'b0), .i_bp_idx(1'b0), .i_bp_addr(4'h0), .i_bp_en(1'b0),
    .q_pc(w_pc), .q_fetch_ce(w_fetch), .q_instr_clk(w_iclk), .q_halted(w_halted),
    .q_bp_hit(w_bp_hit), .q_state(w_state), .q_retired(w_retired)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected PC, wait for the strobe, then pulse {halt,branch,done} for one cycle.
  task automatic run_one(input logic [15:0] exp_pc, input logic [2:0] ev, input logic [15:0] t, input int exp_lat);
    int n = 0;
    exp_q.push_back(exp_pc);
    do begin
      @(negedge clk);
      n++;
    end while (!fetch && n < 20);
    chk("strobe latency", 32'(n), 32'(exp_lat));
    if (ev != 3'b000) begin
      cyc();
      {halt, branch, done} = ev;
      tgt = t;
      cyc();
      {halt, branch, done} = 3'b000;
    end
  endtask

  always @(negedge clk) begin
    if (iclk) pulses++;
    if (fetch) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected strobe at pc %0h", pc);
      end else chk("strobe pc", 32'(pc), 32'(exp_q.pop_front()));
    end
    if (w_fetch) begin
      wseen++;
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected wrap strobe at pc %0h", w_pc);
      end else chk("wrap strobe pc", 32'(w_pc), 32'(wq.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    {rst, mode, step, done, branch, halt, resume, bp_wr, bp_idx, bp_en} = '0;
    tgt = '0;
    bp_addr = '0;
    w_rst = 1'b0;
    w_done = 1'b1;
    #2 rst = 1'b1;
    w_rst = 1'b1;
    #1;
    chk("reset pc", 32'(pc), 0);
    chk("reset fetch", 32'(fetch), 0);
    chk("reset state", 32'(state), 0);
    chk("reset halted", 32'(halted), 0);
    chk("reset bp_hit", 32'(bp_hit), 0);
    chk("reset retired", retired, 0);
    chk("reset instr_clk", 32'(iclk), 0);
    cyc();
    rst = 1'b0;
    run_one(16'd0, 3'b001, 16'h0, 2);
    run_one(16'd1, 3'b001, 16'h0, 1);
    run_one(16'd2, 3'b001, 16'h0, 1);
    run_one(16'd3, 3'b001, 16'h0, 1);
    chk("retired after 4", retired, 4);
    chk("instr_clk pulses", 32'(pulses), 4);
    run_one(16'd4, 3'b001, 16'h0, 1);
    run_one(16'd5, 3'b010, 16'h0040, 1);
    chk("flush state", 32'(state), 3);
    chk("retired after branch", retired, 6);
    run_one(16'h0040, 3'b010, 16'h0006, 4);
    run_one(16'h0006, 3'b001, 16'h0, 4);
    run_one(16'h0007, 3'b111, 16'h0099, 1);
    chk("prio state", 32'(state), 4);
    chk("prio pc", 32'(pc), 8);
    chk("prio halted", 32'(halted), 1);
    chk("prio bp_hit", 32'(bp_hit), 0);
    chk("prio retired", retired, 9);
    cyc();
    chk("halt holds", 32'(state), 4);
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    run_one(16'd8, 3'b001, 16'h0, 1);
    run_one(16'd9, 3'b010, 16'h0002, 1);
    {bp_wr, bp_idx, bp_addr, bp_en} = {1'b1, 1'b0, 16'h0003, 1'b1};
    cyc();
    bp_wr = 1'b0;
    run_one(16'd2, 3'b001, 16'h0, 3);
    cyc();
    chk("bp state", 32'(state), 4);
    chk("bp hit", 32'(bp_hit), 1);
    chk("bp halted", 32'(halted), 1);
    chk("bp pc", 32'(pc), 3);
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    run_one(16'd3, 3'b001, 16'h0, 1);
    run_one(16'd4, 3'b010, 16'h0003, 1);
    for (int i = 0; i < 10 && state != 3'd4; i++) cyc();
    chk("bp retrigger state", 32'(state), 4);
    chk("bp retrigger hit", 32'(bp_hit), 1);
    chk("bp retrigger pc", 32'(pc), 3);
    {bp_wr, bp_en} = 2'b10;
    cyc();
    bp_wr = 1'b0;
    chk("bp hit held", 32'(bp_hit), 1);
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    chk("resume clears bp_hit", 32'(bp_hit), 0);
    run_one(16'd3, 3'b000, 16'h0, 1);
    cyc();
    mode = 1'b1;
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
    step = 1'b1;
    cyc();
    step = 1'b0;
    done = 1'b1;
    cyc();
    done = 1'b0;
    run_one(16'd4, 3'b001, 16'h0, 1);
    repeat (4) cyc();
    chk("step parked state", 32'(state), 1);
    chk("step parked pc", 32'(pc), 5);
    done = 1'b1;
    cyc();
    done = 1'b0;
    chk("stray done pc", 32'(pc), 5);
    chk("stray done retired", retired, 16);
    step = 1'b1;
    run_one(16'd5, 3'b000, 16'h0, 2);
    cyc();
    step = 1'b0;
    #2;
    chk("pre-reset wait", 32'(state), 2);
    rst = 1'b1;
    #1;
    chk("async pc", 32'(pc), 0);
    chk("async fetch", 32'(fetch), 0);
    chk("async state", 32'(state), 0);
    chk("async retired", retired, 0);
    wq.push_back(4'hE);
    wq.push_back(4'hF);
    wq.push_back(4'h0);
    cyc();
    w_rst = 1'b0;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(w_fetch && w_pc == 4'h0) && n < 20);
    end
    @(posedge clk);
    #2;
    chk("wrap strobes", 32'(wseen), 3);
    chk("wrap wait state", 32'(w_state), 2);
    w_rst = 1'b1;
    #1;
    chk("wrap async pc", 32'(w_pc), 32'hE);
    chk("wrap async fetch", 32'(w_fetch), 0);
    chk("wrap async state", 32'(w_state), 0);
    chk("main queue drained", 32'(exp_q.size()), 0);
    chk("wrap queue drained", 32'(wq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
